// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter: arbitrates the single integer register-file write port between the in-order
// main pipeline, the multi-cycle mul/div unit and the FPU.
//
// Each multi-cycle unit owns a one-entry result buffer. Buffered results drain into idle
// pipeline writeback slots under round-robin selection. A per-buffer age counter forces a
// pipeline stall once a buffered result has waited STARVE_LIMIT cycles. The write-port bundle
// is registered.
//
// Parameters:
//   STARVE_LIMIT  cycles a buffered result may wait before forcing its grant (1..15)
//   XLEN          data width
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   pipe_we_i/pipe_rd_i/pipe_data_i    pipeline writeback slot request
//   md_valid_i/md_rd_i/md_data_i       mul/div result, md_ready_o = buffer empty
//   fpu_valid_i/fpu_rd_i/fpu_data_i    FPU integer result, fpu_ready_o = buffer empty
//   pipe_stall_o                       pipeline slot not consumed; pipeline must hold it
//   wb_valid_o/wb_rd_o/wb_data_o       registered regfile write port
//   wb_src_o                           registered source tag: 00 pipe, 01 mul/div, 10 FPU
//
// Optional feature (macro WB_ARB_PERF_CNT_EN):
//   perf_stall_cnt_o      cycles with pipe_stall_o=1 (wraps at 2^32)
//   perf_unit_wait_cnt_o  cycles with a buffer valid but not granted (wraps at 2^32)

module rv32_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,

  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_data_i,

  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic [4:0]      fpu_rd_i,
  input  logic [XLEN-1:0] fpu_data_i,

  output logic            pipe_stall_o,

`ifdef WB_ARB_PERF_CNT_EN
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_unit_wait_cnt_o,
`endif

  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [1:0]      wb_src_o
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  localparam logic [3:0] AgeMax    = 4'hF;

  localparam logic [1:0] SrcPipe = 2'b00;
  localparam logic [1:0] SrcMd   = 2'b01;
  localparam logic [1:0] SrcFpu  = 2'b10;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic            md_vld_q, md_vld_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic [XLEN-1:0] md_data_q, md_data_d;
  logic [3:0]      md_age_q, md_age_d;

  logic            fpu_vld_q, fpu_vld_d;
  logic [4:0]      fpu_rd_q, fpu_rd_d;
  logic [XLEN-1:0] fpu_data_q, fpu_data_d;
  logic [3:0]      fpu_age_q, fpu_age_d;

  // 0: mul/div wins the next tie, 1: FPU wins.
  logic            rr_q, rr_d;

  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [1:0]      wb_src_q, wb_src_d;

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  logic pipe_req;
  logic md_starved, fpu_starved, any_starved;
  logic md_load, fpu_load;
  logic gnt_pipe, gnt_md, gnt_fpu;

  // Ready looks only at registered state, so a buffer being drained this cycle cannot reload
  // on the same edge.
  assign md_ready_o  = ~md_vld_q;
  assign fpu_ready_o = ~fpu_vld_q;

  // Writes to x0 are architecturally dead: accepted but never buffered or written.
  assign pipe_req = pipe_we_i & (pipe_rd_i != 5'd0);
  assign md_load  = md_valid_i & md_ready_o & (md_rd_i != 5'd0);
  assign fpu_load = fpu_valid_i & fpu_ready_o & (fpu_rd_i != 5'd0);

  assign md_starved  = md_vld_q & (md_age_q >= StarveLim);
  assign fpu_starved = fpu_vld_q & (fpu_age_q >= StarveLim);
  assign any_starved = md_starved | fpu_starved;

  // A stall is only meaningful when the pipeline actually has a slot to hold.
  assign pipe_stall_o = any_starved & pipe_req;

  // ---------------------------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    gnt_pipe = 1'b0;
    gnt_md   = 1'b0;
    gnt_fpu  = 1'b0;
    if (any_starved) begin
      if (md_starved && fpu_starved) begin
        gnt_md  = ~rr_q;
        gnt_fpu = rr_q;
      end else begin
        gnt_md  = md_starved;
        gnt_fpu = fpu_starved;
      end
    end else if (pipe_req) begin
      gnt_pipe = 1'b1;
    end else if (md_vld_q && fpu_vld_q) begin
      gnt_md  = ~rr_q;
      gnt_fpu = rr_q;
    end else begin
      gnt_md  = md_vld_q;
      gnt_fpu = fpu_vld_q;
    end
  end

  // Pointer moves past whichever unit was just served; pipe grants leave it alone.
  always_comb begin
    rr_d = rr_q;
    if (gnt_md) begin
      rr_d = 1'b1;
    end else if (gnt_fpu) begin
      rr_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Buffer next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    md_vld_d  = md_vld_q;
    md_rd_d   = md_rd_q;
    md_data_d = md_data_q;
    md_age_d  = md_age_q;
    if (md_load) begin
      md_vld_d  = 1'b1;
      md_rd_d   = md_rd_i;
      md_data_d = md_data_i;
      md_age_d  = 4'd0;
    end else if (gnt_md) begin
      md_vld_d = 1'b0;
      md_age_d = 4'd0;
    end else if (md_vld_q && (md_age_q != AgeMax)) begin
      md_age_d = md_age_q + 4'd1;
    end
  end

  always_comb begin
    fpu_vld_d  = fpu_vld_q;
    fpu_rd_d   = fpu_rd_q;
    fpu_data_d = fpu_data_q;
    fpu_age_d  = fpu_age_q;
    if (fpu_load) begin
      fpu_vld_d  = 1'b1;
      fpu_rd_d   = fpu_rd_i;
      fpu_data_d = fpu_data_i;
      fpu_age_d  = 4'd0;
    end else if (gnt_fpu) begin
      fpu_vld_d = 1'b0;
      fpu_age_d = 4'd0;
    end else if (fpu_vld_q && (fpu_age_q != AgeMax)) begin
      fpu_age_d = fpu_age_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Write-port bundle; address/data/tag hold when nothing is granted
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wb_valid_d = gnt_pipe | gnt_md | gnt_fpu;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;
    if (gnt_pipe) begin
      wb_rd_d   = pipe_rd_i;
      wb_data_d = pipe_data_i;
      wb_src_d  = SrcPipe;
    end else if (gnt_md) begin
      wb_rd_d   = md_rd_q;
      wb_data_d = md_data_q;
      wb_src_d  = SrcMd;
    end else if (gnt_fpu) begin
      wb_rd_d   = fpu_rd_q;
      wb_data_d = fpu_data_q;
      wb_src_d  = SrcFpu;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      md_vld_q   <= 1'b0;
      md_rd_q    <= 5'd0;
      md_data_q  <= '0;
      md_age_q   <= 4'd0;
      fpu_vld_q  <= 1'b0;
      fpu_rd_q   <= 5'd0;
      fpu_data_q <= '0;
      fpu_age_q  <= 4'd0;
      rr_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      wb_src_q   <= SrcPipe;
    end else begin
      md_vld_q   <= md_vld_d;
      md_rd_q    <= md_rd_d;
      md_data_q  <= md_data_d;
      md_age_q   <= md_age_d;
      fpu_vld_q  <= fpu_vld_d;
      fpu_rd_q   <= fpu_rd_d;
      fpu_data_q <= fpu_data_d;
      fpu_age_q  <= fpu_age_d;
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign wb_src_o   = wb_src_q;

`ifdef WB_ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------------------------
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic        unit_waiting;

  assign unit_waiting = (md_vld_q & ~gnt_md) | (fpu_vld_q & ~gnt_fpu);

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_wait_d  = perf_wait_q;
    if (pipe_stall_o) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (unit_waiting) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= 32'd0;
      perf_wait_q  <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_stall_cnt_o     = perf_stall_q;
  assign perf_unit_wait_cnt_o = perf_wait_q;
`endif

endmodule
